// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DETECT = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a registered all-ones flag.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    sat_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with reloadable pattern, valid qualifier and match counter.
// state     | meaning
// ST_IDLE   | en low, nothing sampled
// ST_FILL   | fewer than PAT_LEN-1 bits collected
// ST_DETECT | every sampled bit completes a candidate word
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned        PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1001,
  parameter bit                 OVERLAP  = 1'b1,
  parameter int unsigned        CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               din_valid,
  input  logic               clear,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               busy
);

  localparam int unsigned     FW        = clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]   FILL_LAST = FW'(PAT_LEN - 1);
  localparam logic [FW-1:0]   FILL_FULL = FW'(PAT_LEN);

  state_e             state_q, state_d;
  // Only PAT_LEN-1 history bits are ever needed: the newest bit comes from din.
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               dout_q, dout_d;
  logic [PAT_LEN-1:0] cand;
  logic               sample;
  logic               match;

  assign cand   = {hist_q, din};
  assign sample = en & din_valid & ~clear & ~pat_load &
                  ((state_q == ST_FILL) | (state_q == ST_DETECT));
  assign match  = sample & (fill_q >= FILL_LAST) & (cand == pat_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      pat_q   <= PAT_INIT;
      fill_q  <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    dout_d  = 1'b0;
    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = en ? ST_FILL : ST_IDLE;
    end else if (pat_load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = en ? ST_FILL : ST_IDLE;
    end else if (!en) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: begin
          if (sample) begin
            hist_d = cand[PAT_LEN-2:0];
            fill_d = fill_q + 1'b1;
            if ((fill_q + 1'b1) == FILL_LAST) state_d = ST_DETECT;
          end
        end
        ST_DETECT: begin
          if (sample) begin
            dout_d = match;
            if (match && !OVERLAP) begin
              hist_d  = '0;
              fill_d  = '0;
              state_d = ST_FILL;
            end else begin
              hist_d = cand[PAT_LEN-2:0];
              if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
            end
          end
        end
        default: begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dout = dout_q;
    busy = (state_q != ST_IDLE);
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (clear),
    .inc_i (match),
    .cnt_o (match_cnt),
    .sat_o (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three parameter variants share one stimulus stream.
module tb_seq_detect_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic       din_valid;
  logic       clear;
  logic       pat_load;
  logic [3:0] pat_in;

  logic       dout_a, sat_a, busy_a;
  logic [7:0] cnt_a;
  logic       dout_b, sat_b, busy_b;
  logic [7:0] cnt_b;
  logic       dout_c, sat_c, busy_c;
  logic [1:0] cnt_c;

  int errors = 0;
  int checks = 0;
  int pulses[3];

  // Instance 0: defaults; 1: non-overlapping; 2: 2-bit counter.
  seq_detect_param #(.PAT_LEN(4), .PAT_INIT(4'b1001), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid), .clear(clear),
    .pat_load(pat_load), .pat_in(pat_in), .dout(dout_a), .match_cnt(cnt_a),
    .cnt_sat(sat_a), .busy(busy_a));

  seq_detect_param #(.PAT_LEN(4), .PAT_INIT(4'b1001), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid), .clear(clear),
    .pat_load(pat_load), .pat_in(pat_in), .dout(dout_b), .match_cnt(cnt_b),
    .cnt_sat(sat_b), .busy(busy_b));

  seq_detect_param #(.PAT_LEN(4), .PAT_INIT(4'b1001), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid), .clear(clear),
    .pat_load(pat_load), .pat_in(pat_in), .dout(dout_c), .match_cnt(cnt_c),
    .cnt_sat(sat_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bit stream since the last restart, the enable seen at the
  // previous edge, and the match count, all kept as plain integers.
  bit [31:0] m_word[3];
  int        m_len[3];
  int        m_cnt[3];
  bit        m_dout[3];
  bit        m_act[3];
  bit [3:0]  m_pat;
  int        m_max[3] = '{255, 255, 3};
  bit        m_ovl[3] = '{1'b1, 1'b0, 1'b1};

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_word[k] = 0; m_len[k] = 0; m_cnt[k] = 0; m_dout[k] = 0; m_act[k] = 0;
    end
    m_pat = 4'b1001;
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_dout[k] = 1'b0;
      if (clear) begin
        m_len[k] = 0; m_cnt[k] = 0; m_act[k] = en;
      end else if (pat_load) begin
        m_len[k] = 0; m_act[k] = en;
      end else if (!en) begin
        m_len[k] = 0; m_act[k] = 1'b0;
      end else begin
        if (m_act[k] && din_valid) begin
          m_word[k] = {m_word[k][30:0], din};
          m_len[k]  = m_len[k] + 1;
          if (m_len[k] >= 4 && m_word[k][3:0] == m_pat) begin
            m_dout[k] = 1'b1;
            if (m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
            if (!m_ovl[k]) m_len[k] = 0;
          end
        end
        m_act[k] = 1'b1;
      end
    end
    if (!clear && pat_load) m_pat = pat_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input int k, input logic d,
                          input logic [31:0] c, input logic s, input logic b);
    chk({tag, ".dout"}, {31'b0, d}, {31'b0, m_dout[k]});
    chk({tag, ".match_cnt"}, c, m_cnt[k]);
    chk({tag, ".cnt_sat"}, {31'b0, s}, (m_cnt[k] == m_max[k]) ? 1 : 0);
    chk({tag, ".busy"}, {31'b0, b}, {31'b0, m_act[k]});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst("a", 0, dout_a, 32'(cnt_a), sat_a, busy_a);
      cmp_inst("b", 1, dout_b, 32'(cnt_b), sat_b, busy_b);
      cmp_inst("c", 2, dout_c, 32'(cnt_c), sat_c, busy_c);
      if (dout_a === 1'b1) pulses[0]++;
      if (dout_b === 1'b1) pulses[1]++;
      if (dout_c === 1'b1) pulses[2]++;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b0;
      din_valid = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic zero_pulses();
    for (int k = 0; k < 3; k++) pulses[k] = 0;
  endtask

  task automatic chk_pulses(input string name, input int ea, input int eb, input int ec);
    chk({name, ".pulses_a"}, pulses[0], ea);
    chk({name, ".pulses_b"}, pulses[1], eb);
    chk({name, ".pulses_c"}, pulses[2], ec);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; din = 1'b0; din_valid = 1'b0;
    clear = 1'b0; pat_load = 1'b0; pat_in = 4'b0000;
    zero_pulses();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset.dout", {31'b0, dout_a}, 0);
    chk("reset.cnt", 32'(cnt_a), 0);
    chk("reset.sat", {31'b0, sat_c}, 0);
    chk("reset.busy", {31'b0, busy_a}, 0);

    // Test 1/2: 1001001, overlapping vs non-overlapping
    en = 1'b1;
    idle(1);
    send_bits(32'b1001001, 7);
    idle(2);
    #1;
    chk_pulses("t1", 2, 1, 2);
    chk("t1.cnt_a", 32'(cnt_a), 2);
    chk("t2.cnt_b", 32'(cnt_b), 1);
    chk("t1.sat_c", {31'b0, sat_c}, 0);

    // Dropping en returns to idle but keeps the count
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    #1;
    chk("en_low.busy", {31'b0, busy_a}, 0);
    chk("en_low.cnt_a", 32'(cnt_a), 2);
    en = 1'b1;
    idle(1);
    do_clear();
    idle(1);
    #1;
    chk("clear.cnt_a", 32'(cnt_a), 0);
    zero_pulses();

    // Test 3: valid gaps of three cycles between bits
    send_bit(1'b1); idle(3);
    send_bit(1'b0); idle(3);
    send_bit(1'b0); idle(3);
    send_bit(1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    chk("t3.latency", {31'b0, dout_a}, 1);
    idle(2);
    #1;
    chk_pulses("t3", 1, 1, 1);
    chk("t3.cnt_a", 32'(cnt_a), 1);
    do_clear();
    zero_pulses();

    // Test 4: reload pattern to 0110 mid-sequence
    send_bits(32'b100, 3);
    @(negedge clk);
    pat_load = 1'b1; pat_in = 4'b0110; din = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    pat_load = 1'b0; din_valid = 1'b0;
    send_bits(32'b10010110, 8);
    idle(2);
    #1;
    chk_pulses("t4", 1, 1, 1);
    chk("t4.cnt_a", 32'(cnt_a), 1);
    chk("t4.cnt_b", 32'(cnt_b), 1);
    @(negedge clk);
    pat_load = 1'b1; pat_in = 4'b1001;
    @(negedge clk);
    pat_load = 1'b0;
    do_clear();
    zero_pulses();

    // Test 5: four overlapping matches saturate the 2-bit counter
    send_bits(32'b1001001001001, 13);
    idle(2);
    #1;
    chk_pulses("t5", 4, 2, 4);
    chk("t5.cnt_a", 32'(cnt_a), 4);
    chk("t5.cnt_b", 32'(cnt_b), 2);
    chk("t5.cnt_c", 32'(cnt_c), 3);
    chk("t5.sat_c", {31'b0, sat_c}, 1);
    chk("t5.sat_a", {31'b0, sat_a}, 0);
    do_clear();
    #1;
    chk("t5.clear_cnt_c", 32'(cnt_c), 0);
    chk("t5.clear_sat_c", {31'b0, sat_c}, 0);
    zero_pulses();

    // Test 6: asynchronous reset mid-sequence
    send_bits(32'b1001, 4);
    send_bits(32'b100, 3);
    @(posedge clk);
    #3;
    chk("t6.busy_pre", {31'b0, busy_a}, 1);
    chk("t6.cnt_pre", 32'(cnt_a), 1);
    rst = 1'b0;
    #1;
    chk("t6.rst_cnt_a", 32'(cnt_a), 0);
    chk("t6.rst_busy", {31'b0, busy_a}, 0);
    chk("t6.rst_dout", {31'b0, dout_b}, 0);
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0;
    zero_pulses();
    send_bits(32'b1001, 4);
    idle(2);
    #1;
    chk_pulses("t6", 1, 1, 1);
    chk("t6.cnt_a", 32'(cnt_a), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
